// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: multiplier FSM state type and default width.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam int MUL_W_DEFAULT = 4;

endpackage

// File: rtl/adder4cla.sv
// 4-bit carry-lookahead adder slice; cascaded through co/cin to build wider adders.
module adder4cla (
   output logic [3:0] s,
   output logic       co,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Every carry is expanded from cin directly, so no carry ripples inside the slice.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign s  = w_p ^ w_c[3:0];
   assign co = w_c[4];

endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one partial-product add per cycle,
// W cycles from operand acceptance to product valid, valid/ready on both sides.
module mul_shift_add
   import cpu_pkg::*;
#(
   parameter int W = MUL_W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p,
   output mul_state_t     dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
   // in_ready and out_valid are pure state decodes, so neither depends on the peer's signal.

   localparam int NSLICE = W / 4;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   if ((W % 4) != 0 || W < 4) begin : g_bad_width
      $error("mul_shift_add: W must be a positive multiple of 4");
   end

   mul_state_t    r_state;
   logic [W-1:0]  r_mcand;
   logic [W-1:0]  r_hi;
   logic [W-1:0]  r_lo;
   logic [CW-1:0] r_cnt;

   mul_state_t    w_state_nxt;
   logic [W-1:0]  w_addend;
   logic [W-1:0]  w_sum;
   logic [NSLICE:0] w_carry;
   logic          w_c;

   assign w_carry[0] = 1'b0;

   for (genvar k = 0; k < NSLICE; k++) begin : g_cla
      adder4cla u_cla (
         .s   (w_sum[4*k +: 4]),
         .co  (w_carry[k+1]),
         .a   (r_hi[4*k +: 4]),
         .b   (w_addend[4*k +: 4]),
         .cin (w_carry[k])
      );
   end

   assign w_c = w_carry[NSLICE];

   always_comb begin
      w_addend    = r_lo[0] ? r_mcand : '0;
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)           w_state_nxt = CALC;
         CALC:    if (r_cnt == CNT_LAST)  w_state_nxt = DONE;
         DONE:    if (out_ready)          w_state_nxt = IDLE;
         default:                         w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand <= a;
                  r_hi    <= '0;
                  r_lo    <= b;
                  r_cnt   <= '0;
               end
            end
            CALC: begin
               // {c, sum, lo} >> 1: the add carry lands in hi's MSB.
               r_hi  <= {w_c, w_sum[W-1:1]};
               r_lo  <= {w_sum[0], r_lo[W-1:1]};
               r_cnt <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign p         = {r_hi, r_lo};
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_shift_add.sv
// Bench for mul_shift_add: directed vector table, busy/reset sequences, exhaustive
// W=4 and random W=8 operations compared against plain a*b.
module tb_mul_shift_add;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   mul_state_t  dbg4;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   mul_state_t  dbg8;

   int checks;
   int failures;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp_p;
      int         stall;
   } vec_t;

   vec_t vecs[5];

   mul_shift_add #(.W(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .p         (p4),
      .dbg_state (dbg4)
   );

   mul_shift_add #(.W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .p         (p8),
      .dbg_state (dbg8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic cur_in_ready(input int w);
      return (w == 4) ? in_ready4 : in_ready8;
   endfunction

   function automatic logic cur_out_valid(input int w);
      return (w == 4) ? out_valid4 : out_valid8;
   endfunction

   function automatic logic [15:0] cur_p(input int w);
      return (w == 4) ? {8'd0, p4} : p8;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic set_out_ready(input int w, input logic v);
      if (w == 4) out_ready4 = v;
      else        out_ready8 = v;
   endtask

   task automatic send(input int w, input logic [15:0] av, input logic [15:0] bv);
      int n;
      n = 0;
      while (!cur_in_ready(w) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 1, 0);
      if (w == 4) begin
         in_valid4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
      end else begin
         in_valid8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0];
      end
      @(posedge clk); #1;
      if (w == 4) in_valid4 = 1'b0;
      else        in_valid8 = 1'b0;
      exp_q.push_back(av * bv);
   endtask

   task automatic wait_out(input int w, input int start);
      int   lat;
      logic ir_bad;
      lat    = start;
      ir_bad = 1'b0;
      while (!cur_out_valid(w) && lat < 200) begin
         if (cur_in_ready(w)) ir_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, w);
      check("in_ready_busy", ir_bad, 0);
   endtask

   task automatic drain(input int w, input int stall);
      logic [15:0] exp;
      exp = exp_q.pop_front();
      check("product", cur_p(w), exp);
      for (int i = 0; i < stall; i++) begin
         set_out_ready(w, 1'b0);
         @(posedge clk); #1;
         check("stall_valid", cur_out_valid(w), 1);
         check("stall_p", cur_p(w), exp);
         check("stall_in_ready", cur_in_ready(w), 0);
      end
      set_out_ready(w, 1'b1);
      @(posedge clk); #1;
      set_out_ready(w, 1'b0);
      check("valid_drop", cur_out_valid(w), 0);
      check("in_ready_after", cur_in_ready(w), 1);
   endtask

   task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input int stall);
      send(w, av, bv);
      wait_out(w, 0);
      drain(w, stall);
   endtask

   initial begin
      logic spurious;
      checks   = 0;
      failures = 0;
      in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0;
      in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0;

      vecs[0] = '{a: 4'd3,  b: 4'd5,  exp_p: 8'd15,  stall: 0};
      vecs[1] = '{a: 4'd15, b: 4'd15, exp_p: 8'd225, stall: 0};
      vecs[2] = '{a: 4'd0,  b: 4'd9,  exp_p: 8'd0,   stall: 0};
      vecs[3] = '{a: 4'd9,  b: 4'd0,  exp_p: 8'd0,   stall: 0};
      vecs[4] = '{a: 4'd7,  b: 4'd6,  exp_p: 8'd42,  stall: 6};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready4", in_ready4, 1);
      check("rst_out_valid4", out_valid4, 0);
      check("rst_p4", p4, 0);
      check("rst_in_ready8", in_ready8, 1);
      check("rst_out_valid8", out_valid8, 0);
      check("rst_p8", p8, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table: the table's expected products, not the model, are checked here.
      for (int i = 0; i < 5; i++) begin
         send(4, {12'd0, vecs[i].a}, {12'd0, vecs[i].b});
         void'(exp_q.pop_back());
         exp_q.push_back({8'd0, vecs[i].exp_p});
         wait_out(4, 0);
         drain(4, vecs[i].stall);
      end

      // in_valid during CALC must be ignored.
      send(4, 16'd12, 16'd11);
      in_valid4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_in_ready", in_ready4, 0);
      in_valid4 = 1'b0;
      wait_out(4, 2);
      drain(4, 1);

      // Asynchronous reset mid-CALC discards the operation.
      send(4, 16'd13, 16'd7);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready4, 1);
      check("midrst_out_valid", out_valid4, 0);
      check("midrst_p", p4, 0);
      check("midrst_state", dbg4, IDLE);
      void'(exp_q.pop_back());
      @(posedge clk); #3;
      rst_n = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid4) spurious = 1'b1;
      end
      check("no_spurious_valid", spurious, 0);
      run_op(4, 16'd5, 16'd5, 0);

      // Exhaustive W=4 with random output stalls.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            run_op(4, 16'(ai), 16'(bi), int'($urandom_range(0, 3)));
         end
      end

      // Random W=8, including the all-ones corner.
      run_op(8, 16'd255, 16'd255, 2);
      for (int i = 0; i < 40; i++) begin
         run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)));
      end

      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
